// File: rtl/rggen_register_initiator.sv
// rggen_register_initiator: initiator end of the register access bus.
// Accepts one host command at a time, drives it to REGISTERS responders,
// waits for the selected responder to complete and returns status/read data.
// Optional feature: define RGGEN_REGISTER_INITIATOR_TIMEOUT_EN to abort an
// access that has not completed after TIMEOUT_CYCLES cycles with SLVERR.
module rggen_register_initiator #(
   parameter int unsigned ADDRESS_WIDTH  = 8,
   parameter int unsigned BUS_WIDTH      = 32,
   parameter int unsigned REGISTERS      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_req_valid,
   output logic                           o_req_ready,
   input  logic                           i_req_write,
   input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
   input  logic [BUS_WIDTH-1:0]           i_req_write_data,
   input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [1:0]                     o_rsp_status,
   output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
   output logic                           o_register_valid,
   output logic [1:0]                     o_register_access,
   output logic [ADDRESS_WIDTH-1:0]       o_register_address,
   output logic [BUS_WIDTH-1:0]           o_register_write_data,
   output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
   input  logic [REGISTERS-1:0]           i_register_active,
   input  logic [REGISTERS-1:0]           i_register_ready,
   input  logic [2*REGISTERS-1:0]         i_register_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

   localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
   localparam int unsigned ALIGN_BITS   = $clog2(STROBE_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = ~ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);

   localparam logic [1:0] STATUS_OKAY   = 2'b00;
   localparam logic [1:0] STATUS_SLVERR = 2'b10;
   localparam logic [1:0] ACCESS_NONE   = 2'b00;

   // Reject configurations the datapath cannot represent.
   if ((BUS_WIDTH % 8) != 0 || BUS_WIDTH == 0 || REGISTERS < 1 || TIMEOUT_CYCLES < 1) begin : g_invalid_parameters
      $error("rggen_register_initiator: invalid parameter set");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      RESPONSE = 2'd2
   } state_e;

   state_e                    state_q;
   state_e                    state_d;

   logic                      sel_ready;
   logic [1:0]                sel_status;
   logic [BUS_WIDTH-1:0]      sel_read_data;
   logic                      one_hot;
   logic                      hit;
   logic                      timeout;
   logic                      done;
   logic [1:0]                done_status;
   logic [BUS_WIDTH-1:0]      done_read_data;

   logic                      register_valid_d;
   logic [1:0]                register_access_d;
   logic [ADDRESS_WIDTH-1:0]  register_address_d;
   logic [BUS_WIDTH-1:0]      register_write_data_d;
   logic [STROBE_WIDTH-1:0]   register_strobe_d;
   logic                      rsp_valid_d;
   logic [1:0]                rsp_status_d;
   logic [BUS_WIDTH-1:0]      rsp_read_data_d;

   assign o_req_ready = (state_q == IDLE);

   // Pick the fields of the (single) active responder.
   always_comb begin
      sel_ready     = 1'b0;
      sel_status    = STATUS_OKAY;
      sel_read_data = '0;
      for (int unsigned k = 0; k < REGISTERS; k++) begin
         if (i_register_active[k]) begin
            sel_ready     = i_register_ready[k];
            sel_status    = i_register_status[2*k+:2];
            sel_read_data = i_register_read_data[BUS_WIDTH*k+:BUS_WIDTH];
         end
      end
   end

   // Completion decision: decode error, selected responder ready, or timeout.
   assign one_hot        = (i_register_active != '0) &&
                           ((i_register_active & (i_register_active - REGISTERS'(1))) == '0);
   assign hit            = one_hot && sel_ready;
   assign done           = !one_hot || hit || timeout;
   assign done_status    = hit ? sel_status : STATUS_SLVERR;
   assign done_read_data = (hit && !o_register_access[0]) ? sel_read_data : '0;

`ifdef RGGEN_REGISTER_INITIATOR_TIMEOUT_EN
   localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   logic [COUNT_WIDTH-1:0] timeout_count;

   // Count ACCESS cycles that end without completion; cleared outside ACCESS.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timeout_count <= '0;
      end else if (state_q != ACCESS) begin
         timeout_count <= '0;
      end else if (!done) begin
         timeout_count <= timeout_count + COUNT_WIDTH'(1);
      end
   end

   // The cycle in which the count would reach the limit is the last one allowed.
   assign timeout = (state_q == ACCESS) && (timeout_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q               <= IDLE;
         o_register_valid      <= 1'b0;
         o_register_access     <= ACCESS_NONE;
         o_register_address    <= '0;
         o_register_write_data <= '0;
         o_register_strobe     <= '0;
         o_rsp_valid           <= 1'b0;
         o_rsp_status          <= STATUS_OKAY;
         o_rsp_read_data       <= '0;
      end else begin
         state_q               <= state_d;
         o_register_valid      <= register_valid_d;
         o_register_access     <= register_access_d;
         o_register_address    <= register_address_d;
         o_register_write_data <= register_write_data_d;
         o_register_strobe     <= register_strobe_d;
         o_rsp_valid           <= rsp_valid_d;
         o_rsp_status          <= rsp_status_d;
         o_rsp_read_data       <= rsp_read_data_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_req_valid) state_d = ACCESS;
         ACCESS:   if (done)        state_d = RESPONSE;
         RESPONSE: if (i_rsp_ready) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; everything holds unless updated.
   always_comb begin
      register_valid_d      = o_register_valid;
      register_access_d     = o_register_access;
      register_address_d    = o_register_address;
      register_write_data_d = o_register_write_data;
      register_strobe_d     = o_register_strobe;
      rsp_valid_d           = o_rsp_valid;
      rsp_status_d          = o_rsp_status;
      rsp_read_data_d       = o_rsp_read_data;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               register_valid_d      = 1'b1;
               register_access_d     = {1'b1, i_req_write};
               register_address_d    = i_req_address & ADDRESS_MASK;
               register_write_data_d = i_req_write ? i_req_write_data : '0;
               register_strobe_d     = i_req_write ? i_req_strobe : '1;
            end
         end
         ACCESS: begin
            if (done) begin
               register_valid_d  = 1'b0;
               register_access_d = ACCESS_NONE;
               rsp_valid_d       = 1'b1;
               rsp_status_d      = done_status;
               rsp_read_data_d   = done_read_data;
            end
         end
         RESPONSE: begin
            if (i_rsp_ready) rsp_valid_d = 1'b0;
         end
         default: begin
            register_valid_d = 1'b0;
            rsp_valid_d      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Scoreboard bench for rggen_register_initiator with two responders.
module tb_rggen_register_initiator;

   localparam int unsigned AW   = 8;
   localparam int unsigned BW   = 32;
   localparam int unsigned NREG = 2;
   localparam int unsigned TMO  = 4;
   localparam int unsigned SW   = BW / 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [AW-1:0]        req_address;
   logic [BW-1:0]        req_write_data;
   logic [SW-1:0]        req_strobe;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_status;
   logic [BW-1:0]        rsp_read_data;
   logic                 reg_valid;
   logic [1:0]           reg_access;
   logic [AW-1:0]        reg_address;
   logic [BW-1:0]        reg_write_data;
   logic [SW-1:0]        reg_strobe;
   logic [NREG-1:0]      reg_active;
   logic [NREG-1:0]      reg_ready;
   logic [2*NREG-1:0]    reg_status;
   logic [BW*NREG-1:0]   reg_read_data;

   always #5 clk = ~clk;

   rggen_register_initiator #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .REGISTERS     (NREG),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_req_valid          (req_valid),
      .o_req_ready          (req_ready),
      .i_req_write          (req_write),
      .i_req_address        (req_address),
      .i_req_write_data     (req_write_data),
      .i_req_strobe         (req_strobe),
      .o_rsp_valid          (rsp_valid),
      .i_rsp_ready          (rsp_ready),
      .o_rsp_status         (rsp_status),
      .o_rsp_read_data      (rsp_read_data),
      .o_register_valid     (reg_valid),
      .o_register_access    (reg_access),
      .o_register_address   (reg_address),
      .o_register_write_data(reg_write_data),
      .o_register_strobe    (reg_strobe),
      .i_register_active    (reg_active),
      .i_register_ready     (reg_ready),
      .i_register_status    (reg_status),
      .i_register_read_data (reg_read_data)
   );

   // One transaction: the command plus how the responders behave for it.
   typedef struct {
      bit          write;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strobe;
      logic [1:0]  active;
      int          wait0;
      int          wait1;
      logic [1:0]  st0;
      logic [1:0]  st1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      int          rsp_delay;
      bit          drop;
   } scen_t;

   typedef struct {
      logic [1:0]  status;
      logic [31:0] rdata;
      int          vcyc;
      int          accept_cyc;
      int          rsp_delay;
   } exp_t;

   scen_t scen_q[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: outcome of a transaction from the bus rules alone.
   function automatic exp_t model(input scen_t s);
      exp_t        e;
      int          w;
      logic [1:0]  st;
      logic [31:0] rd;
      e.rsp_delay  = s.rsp_delay;
      e.accept_cyc = 0;
      if (s.active == 2'b01 || s.active == 2'b10) begin
         w  = s.active[1] ? s.wait1 : s.wait0;
         st = s.active[1] ? s.st1 : s.st0;
         rd = s.active[1] ? s.rd1 : s.rd0;
         e.status = st;
         e.rdata  = s.write ? 32'h0 : rd;
         e.vcyc   = w + 1;
`ifdef RGGEN_REGISTER_INITIATOR_TIMEOUT_EN
         if (w >= int'(TMO)) begin
            e.status = 2'b10;
            e.rdata  = 32'h0;
            e.vcyc   = int'(TMO);
         end
`endif
      end else begin
         e.status = 2'b10;
         e.rdata  = 32'h0;
         e.vcyc   = 1;
      end
      return e;
   endfunction

   function automatic scen_t mk(input bit write, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strobe, input logic [1:0] active,
                                input int wait0, input int wait1, input logic [1:0] st0,
                                input logic [1:0] st1, input logic [31:0] rd0,
                                input logic [31:0] rd1, input int rsp_delay);
      scen_t s;
      s.write = write; s.addr = addr; s.wdata = wdata; s.strobe = strobe; s.active = active;
      s.wait0 = wait0; s.wait1 = wait1; s.st0 = st0; s.st1 = st1; s.rd0 = rd0; s.rd1 = rd1;
      s.rsp_delay = rsp_delay; s.drop = 1'b0;
      return s;
   endfunction

   function automatic scen_t rand_scen();
      logic [1:0] act;
      logic [3:0] pick;
      pick = 4'($urandom_range(0, 9));
      act  = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : (pick == 8) ? 2'b00 : 2'b11;
      return mk(1'($urandom), 8'($urandom), $urandom, 4'($urandom), act,
                $urandom_range(0, 5), $urandom_range(0, 5), 2'($urandom), 2'($urandom),
                $urandom, $urandom, $urandom_range(0, 3));
   endfunction

   // Present a command from a negedge; returns at the negedge after acceptance.
   task automatic send(input scen_t s);
      int   n = 0;
      exp_t e;
      req_valid      = 1'b1;
      req_write      = s.write;
      req_address    = s.addr;
      req_write_data = s.wdata;
      req_strobe     = s.strobe;
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      e            = model(s);
      e.accept_cyc = cyc;
      if (!s.drop) exp_q.push_back(e);
      scen_q.push_back(s);
      @(negedge clk);
      req_valid      = 1'b0;
      req_write      = 1'($urandom);
      req_address    = 8'($urandom);
      req_write_data = $urandom;
      req_strobe     = 4'($urandom);
   endtask

   // Responder model: drives the register side and checks the access fields.
   initial begin
      scen_t s;
      exp_t  e;
      bit    busy = 1'b0;
      int    n    = 0;
      s = mk(1'b0, 8'h0, 32'h0, 4'h0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
      forever begin
         @(negedge clk);
         if (reg_valid) begin
            if (!busy) begin
               if (scen_q.size() == 0) chk("reg_access_unexpected", 64'd0, 64'd1);
               else s = scen_q.pop_front();
               busy = 1'b1;
               n    = 0;
            end
            chk("reg_address", 64'(reg_address), 64'(s.addr & 8'hFC));
            chk("reg_access", 64'(reg_access), s.write ? 64'd3 : 64'd2);
            chk("reg_strobe", 64'(reg_strobe), s.write ? 64'(s.strobe) : 64'hF);
            chk("reg_write_data", 64'(reg_write_data), s.write ? 64'(s.wdata) : 64'd0);
            chk("req_ready_in_access", 64'(req_ready), 64'd0);
            reg_active    = s.active;
            reg_ready     = {n >= s.wait1, n >= s.wait0};
            reg_status    = {s.st1, s.st0};
            reg_read_data = {s.rd1, s.rd0};
            n++;
         end else begin
            if (busy) begin
               busy = 1'b0;
               if (!s.drop) begin
                  e = model(s);
                  chk("reg_valid_cycles", 64'(n), 64'(e.vcyc));
               end
               chk("reg_access_cleared", 64'(reg_access), 64'd0);
            end
            reg_active    = 2'($urandom);
            reg_ready     = 2'($urandom);
            reg_status    = 4'($urandom);
            reg_read_data = {$urandom, $urandom};
         end
      end
   end

   // Response monitor: pops the scoreboard when a response appears.
   initial begin
      exp_t cur;
      bit   have  = 1'b0;
      bit   after = 1'b0;
      int   hold  = 0;
      cur.status = 2'b00; cur.rdata = 32'h0; cur.vcyc = 0; cur.accept_cyc = 0; cur.rsp_delay = 0;
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (after) begin
            after = 1'b0;
            chk("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
            chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
            chk("rsp_status_kept", 64'(rsp_status), 64'(cur.status));
            chk("rsp_read_data_kept", 64'(rsp_read_data), 64'(cur.rdata));
         end
         if (rsp_valid) begin
            if (!have) begin
               if (exp_q.size() == 0) chk("rsp_unexpected", 64'd0, 64'd1);
               else begin
                  cur = exp_q.pop_front();
                  chk("rsp_latency", 64'(cyc), 64'(cur.accept_cyc + cur.vcyc + 1));
               end
               have = 1'b1;
               hold = 0;
            end
            chk("rsp_status", 64'(rsp_status), 64'(cur.status));
            chk("rsp_read_data", 64'(rsp_read_data), 64'(cur.rdata));
            chk("req_ready_in_rsp", 64'(req_ready), 64'd0);
            if (hold >= cur.rsp_delay) begin
               rsp_ready = 1'b1;
               have      = 1'b0;
               after     = 1'b1;
            end else begin
               rsp_ready = 1'b0;
               hold++;
            end
         end else begin
            rsp_ready = 1'($urandom);
         end
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      chk({tag, "_reg_valid"}, 64'(reg_valid), 64'd0);
      chk({tag, "_reg_access"}, 64'(reg_access), 64'd0);
      chk({tag, "_reg_address"}, 64'(reg_address), 64'd0);
      chk({tag, "_reg_write_data"}, 64'(reg_write_data), 64'd0);
      chk({tag, "_reg_strobe"}, 64'(reg_strobe), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
      chk({tag, "_rsp_read_data"}, 64'(rsp_read_data), 64'd0);
   endtask

   // Stimulus: directed cases, random traffic, reset mid-access, drain.
   initial begin
      scen_t s;
      int    n = 0;
      rst_n          = 1'b0;
      req_valid      = 1'b0;
      req_write      = 1'b0;
      req_address    = '0;
      req_write_data = '0;
      req_strobe     = '0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      send(mk(1'b0, 8'h07, 32'h0, 4'h0, 2'b10, 0, 0, 2'b11, 2'b00, 32'h1111_2222, 32'hDEAD_BEEF, 0));
      send(mk(1'b1, 8'h20, 32'h1234_5678, 4'b0101, 2'b01, 3, 0, 2'b00, 2'b10, 32'hCAFE_F00D, 32'h1, 0));
      send(mk(1'b0, 8'h40, 32'h0, 4'h0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h5555_AAAA, 32'hAAAA_5555, 1));
      send(mk(1'b0, 8'h44, 32'h0, 4'h0, 2'b11, 0, 0, 2'b00, 2'b00, 32'h0BAD_0001, 32'h0BAD_0002, 0));
      send(mk(1'b0, 8'h13, 32'h0, 4'h0, 2'b01, 1, 0, 2'b01, 2'b00, 32'h7777_8888, 32'h0, 5));
      send(mk(1'b1, 8'h33, 32'hA5A5_5A5A, 4'hC, 2'b01, 100, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0));

      for (int i = 0; i < 40; i++) begin
         send(rand_scen());
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      s      = mk(1'b0, 8'h50, 32'h0, 4'h0, 2'b01, 200, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
      s.drop = 1'b1;
      send(s);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(mk(1'b0, 8'h0A, 32'h0, 4'h0, 2'b10, 0, 2, 2'b00, 2'b00, 32'h0, 32'h1357_9BDF, 2));

      while ((exp_q.size() != 0 || rsp_valid || reg_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      chk("responder_queue_drained", 64'(scen_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rggen_register_initiator.md
Name: rggen_register_initiator

Overview:
- Initiator end of the register access bus.
- Accepts one host command at a time on a valid/ready request channel and drives it to REGISTERS register responders.
- Waits for the responding register to complete, collects its status and read data, and returns them on a valid/ready response channel.
- Sits between a bus-protocol front end and the register array.

Parameters:
- ADDRESS_WIDTH, 8, width of request and register addresses.
- BUS_WIDTH, 32, data width; multiple of 8.
- REGISTERS, 1, number of attached register responders (≥1).
- TIMEOUT_CYCLES, 64, ACCESS-state cycle limit (used only with the optional feature); ≥1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  command valid
- o_req_ready  out  1  command accepted when valid&&ready
- i_req_write  in  1  1=write, 0=read
- i_req_address  in  ADDRESS_WIDTH  byte address
- i_req_write_data  in  BUS_WIDTH  write data
- i_req_strobe  in  BUS_WIDTH/8  byte enables (writes)
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response taken
- o_rsp_status  out  2  2'b00 OKAY, 2'b10 SLVERR
- o_rsp_read_data  out  BUS_WIDTH  read data
- o_register_valid  out  1  access valid to all registers
- o_register_access  out  2  2'b10 read, 2'b11 write (bit0=data/write, bit1=non-posted)
- o_register_address  out  ADDRESS_WIDTH  aligned address
- o_register_write_data  out  BUS_WIDTH  write data
- o_register_strobe  out  BUS_WIDTH/8  byte strobes
- i_register_active  in  REGISTERS  per-register address match
- i_register_ready  in  REGISTERS  per-register completion
- i_register_status  in  2*REGISTERS  per-register status, register k at [2k+:2]
- i_register_read_data  in  BUS_WIDTH*REGISTERS  per-register read data, register k at [BUS_WIDTH*k+:BUS_WIDTH]

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk.
- Reset values: state IDLE; o_register_valid=0, o_register_access=2'b00, o_register_address/write_data/strobe=0; o_rsp_valid=0, o_rsp_status=2'b00, o_rsp_read_data=0.
- o_req_ready = (state==IDLE), so it reads 1 during and after reset.
- FSM IDLE -> ACCESS -> RESPONSE -> IDLE.
- IDLE → ACCESS on i_req_valid (accept):
  - Latch the command.
  - o_register_address = i_req_address with low $clog2(BUS_WIDTH/8) bits cleared.
  - Access = {1'b1, i_req_write}.
  - Writes: strobe = i_req_strobe, write_data = i_req_write_data. Reads: strobe = all ones, write_data = 0.
  - o_register_valid=1 from the next cycle.
- ACCESS: outputs held stable every cycle. Per cycle:
  - a) i_register_active==0: complete with SLVERR, read_data 0.
  - b) more than one active bit: complete with SLVERR, read_data 0.
  - c) exactly one active bit k with ready[k]=1: complete with status[k]; read_data = read_data[k] for reads, 0 for writes.
  - d) otherwise: stay.
  - Completion registers o_rsp_status/o_rsp_read_data, drops o_register_valid (and access to 2'b00), and enters RESPONSE.
- RESPONSE: o_rsp_valid=1, response fields stable. On i_rsp_ready → IDLE, o_rsp_valid=0, fields keep their last value.
- Latency:
  - Accept edge T; register valid in cycle T+1.
  - Register completing in cycle T+1 gives o_rsp_valid in T+2.
  - Minimum 3 cycles per transaction; no back-to-back accept.
- Inputs i_register_* are ignored outside ACCESS.
- Reset asserted mid-transaction: immediate return to reset values; the pending transaction is dropped with no response.

Optional Feature:
- Macro RGGEN_REGISTER_INITIATOR_TIMEOUT_EN.
- Defined: a counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to ACCESS and increments each ACCESS cycle without completion. When it reaches TIMEOUT_CYCLES, the transaction completes with SLVERR and read_data 0. Normal completion in the same cycle wins.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Read, REGISTERS=2, address 0x07: register 1 active, ready in first ACCESS cycle, read_data[1]=0xDEADBEEF, status 00 -> o_register_address=0x04, access 2'b10, strobe 4'hF; o_rsp_valid 2 cycles after accept, read_data 0xDEADBEEF, status 00.
- Write 0x12345678, strobe 4'b0101: register 0 ready after 3 wait cycles -> access 2'b11, strobe/data held 4 cycles; response status 00, read_data 0.
- No active register -> o_rsp_status 2'b10, read_data 0, o_register_valid high exactly one cycle.
- Both active bits set, both ready -> SLVERR, read_data 0.
- i_rsp_ready low 5 cycles -> o_rsp_valid and fields stable, o_req_ready 0 throughout; after ready, o_req_ready=1 next cycle. Reset pulsed in ACCESS -> all outputs return to reset values with no response.
- With macro, TIMEOUT_CYCLES=4, active never ready -> SLVERR after exactly 4 ACCESS cycles. Without macro -> still waiting at cycle 100.
